button_events: RTL

Classifies a debounced push-button level into one-cycle user events: press, release, click, double-click, long-press and auto-repeat. It sits directly downstream of `debouncer`: `debouncer.bit_out` drives `level` here. Its pulses feed the UI/control logic, so that logic never times button holds itself.

---
 rtl/button_events.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/button_events.sv
// Classifies a debounced button level into one-cycle press/release/click/double-click/long-press/repeat events.
// The release and repeat events are exported as release_pulse and repeat_pulse because both names are SystemVerilog keywords.
module button_events #(
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    parameter int DOUBLE_CYCLES = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pressed,
    output logic press,
    output logic release_pulse,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W     = $clog2(MAX_CYCLES + 1);
    localparam int WIN_W      = (DOUBLE_CYCLES > 0) ? $clog2(DOUBLE_CYCLES + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] LONG_VAL   = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] REPEAT_VAL = HOLD_W'(REPEAT_CYCLES);
    localparam logic [WIN_W-1:0]  WIN_ONE    = WIN_W'(1);
    localparam logic [WIN_W-1:0]  WIN_ZERO   = WIN_W'(0);
    localparam logic [WIN_W-1:0]  WIN_LOAD   = WIN_W'(DOUBLE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HELD  = 3'd1,
        ST_LONG  = 3'd2,
        ST_GAP   = 3'd3,
        ST_HELD2 = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                prev_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_next_s;
    logic [HOLD_W-1:0]   hold_inc_s;
    logic [WIN_W-1:0]    win_cnt_r;
    logic [WIN_W-1:0]    win_next_s;
    logic                rise_s;
    logic                fall_s;
    logic                pressed_s;
    logic                press_s;
    logic                release_s;
    logic                click_s;
    logic                double_s;
    logic                long_s;
    logic                repeat_s;

    // Edge detection and saturating hold increment.
    always_comb begin
        rise_s = level & ~prev_r;
        fall_s = ~level & prev_r;
        if (hold_cnt_r == HOLD_MAX) begin
            hold_inc_s = hold_cnt_r;
        end else begin
            hold_inc_s = hold_cnt_r + HOLD_ONE;
        end
    end

    // State register plus registered event outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            prev_r        <= 1'b0;
            hold_cnt_r    <= '0;
            win_cnt_r     <= '0;
            pressed       <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            click         <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            prev_r        <= level;
            hold_cnt_r    <= hold_next_s;
            win_cnt_r     <= win_next_s;
            pressed       <= pressed_s;
            press         <= press_s;
            release_pulse <= release_s;
            click         <= click_s;
            double_click  <= double_s;
            long_press    <= long_s;
            repeat_pulse  <= repeat_s;
        end
    end

    // Next-state and counter logic; a fall always takes priority over hold thresholds.
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_cnt_r;
        win_next_s   = win_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_next_s = ST_HELD;
                    hold_next_s  = HOLD_ONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HELD, ST_HELD2: begin
                if (fall_s) begin
                    if ((state_r == ST_HELD) && (DOUBLE_CYCLES > 0)) begin
                        state_next_s = ST_GAP;
                        win_next_s   = WIN_LOAD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else if (hold_cnt_r == LONG_VAL) begin
                    state_next_s = ST_LONG;
                    hold_next_s  = HOLD_ONE;
                end else begin
                    hold_next_s  = hold_inc_s;
                end
            end
            ST_LONG: begin
                if (fall_s) begin
                    state_next_s = ST_IDLE;
                end else if ((REPEAT_CYCLES > 0) && (hold_cnt_r == REPEAT_VAL)) begin
                    hold_next_s  = HOLD_ONE;
                end else begin
                    hold_next_s  = hold_inc_s;
                end
            end
            ST_GAP: begin
                // A rise on the edge where the window expires counts as a fresh press.
                if (rise_s) begin
                    hold_next_s = HOLD_ONE;
                    if (win_cnt_r > WIN_ONE) begin
                        state_next_s = ST_HELD2;
                    end else begin
                        state_next_s = ST_HELD;
                    end
                end else if (win_cnt_r <= WIN_ONE) begin
                    state_next_s = ST_IDLE;
                    win_next_s   = WIN_ZERO;
                end else begin
                    win_next_s   = win_cnt_r - WIN_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                hold_next_s  = '0;
                win_next_s   = '0;
            end
        endcase
    end

    // Event decode from the current state and sampled edges.
    always_comb begin
        press_s   = 1'b0;
        release_s = 1'b0;
        click_s   = 1'b0;
        double_s  = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;
        pressed_s = (state_next_s == ST_HELD) || (state_next_s == ST_HELD2) ||
                    (state_next_s == ST_LONG);
        case (state_r)
            ST_IDLE, ST_GAP: begin
                press_s = rise_s;
            end
            ST_HELD: begin
                if (fall_s) begin
                    release_s = 1'b1;
                    click_s   = 1'b1;
                end else begin
                    long_s    = (hold_cnt_r == LONG_VAL);
                end
            end
            ST_HELD2: begin
                if (fall_s) begin
                    release_s = 1'b1;
                    double_s  = 1'b1;
                end else begin
                    long_s    = (hold_cnt_r == LONG_VAL);
                end
            end
            ST_LONG: begin
                if (fall_s) begin
                    release_s = 1'b1;
                end else begin
                    repeat_s  = (REPEAT_CYCLES > 0) && (hold_cnt_r == REPEAT_VAL);
                end
            end
            default: begin
                press_s = 1'b0;
            end
        endcase
    end

endmodule
